uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single UART transmit path (the `wr_uart`/`w_data` write port of the `uart` block's TX FIFO) between several byte-stream requesters, e.g. the RX echo path and a status-message generator. Round-robin arbitration at packet granularity: once a requester is granted, it keeps the port until it sends a byte flagged `last`. The block sits between the requesters and `uart` and honours the FIFO's `tx_full` back-pressure.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `TIMEOUT`, 1000: idle cycles before a stalled grant is revoked (used only with `UART_ARB_TIMEOUT_EN`).

- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NREQ: requester i has a byte on `req_data[8*i+7:8*i]`.
- `req_last` in NREQ: that byte ends requester i's packet.
- `req_data` in 8*NREQ: packed byte lanes.
- `req_ready` out NREQ: byte on lane i is accepted this cycle.
- `tx_full` in 1: UART TX FIFO full.
- `wr_uart` out 1: write strobe to the UART TX FIFO.
- `w_data` out 8: byte to the UART TX FIFO.
- `grant` out NREQ: one-hot current owner, registered.
- `busy` out 1: a grant is held.
- `timeout` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE (grant = 0) and LOCKED (grant one-hot).
- IDLE: if any `req_valid` is high, grant the first valid index searching upward from `last_ptr+1` modulo NREQ, then enter LOCKED on the next edge. No byte is accepted in the arbitration cycle.
- LOCKED, owner k: `req_ready[k] = !tx_full`; other ready bits are 0. Combinational: `wr_uart = req_valid[k] & !tx_full`, `w_data` = lane k. `w_data` is 0 when no grant is held.
- Accepted byte with `req_last[k]`=1: next state IDLE, `last_ptr` <= k, grant clears.
- The owner may drop `req_valid` mid-packet. The grant is held and nothing is written.
- `tx_full` high: nothing is accepted, state and data are held, no byte is lost or duplicated.
- Non-owners that request while LOCKED wait. Their `req_valid` must stay stable until accepted.
- Reset: state IDLE, `grant`=0, `busy`=0, `timeout`=0, `wr_uart`=0, `w_data`=0, `last_ptr`=NREQ-1 (requester 0 wins first). Reset mid-packet drops the grant immediately. The partial packet is abandoned.
- `rst` has priority over every other event.

## Timing
- Arbitration latency: 1 cycle from `req_valid` rising in IDLE to `grant` set. The first byte can be written on the 2nd cycle.
- Throughput while LOCKED: 1 byte/cycle when `tx_full`=0.
- Packet turnaround: the last byte is accepted at cycle n, IDLE at n+1, the next grant at n+2. That leaves 1 dead cycle between packets.
- `busy` = |grant (registered).

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter counts LOCKED cycles with no accepted byte. It clears on each accept and on entering LOCKED.
  - If `req_valid[k]`=0 for TIMEOUT consecutive cycles, the block forces IDLE, sets `last_ptr` <= k and pulses `timeout` for 1 cycle.
  - Cycles stalled by `tx_full` with `req_valid[k]`=1 do not count.
- Not defined: no counter is built. `timeout` is tied to 0. A stalled owner holds the port indefinitely.

## Test plan
- After reset, req0 and req1 are valid together, each sending a 2-byte packet (0x41,0x42 / 0x43,0x44) -> grant=01 on the 1st cycle; FIFO receives 0x41,0x42, one dead cycle, then 0x43,0x44.
- req1 sends 3 packets back-to-back while req0 has 1 packet pending -> order is req1, req0, req1, req1 (round-robin, no starvation).
- `tx_full` is asserted for 5 cycles in the middle of a 4-byte packet 0x10..0x13 -> `wr_uart`=0 during the stall; the FIFO sees exactly 0x10,0x11,0x12,0x13.
- `rst` is pulsed while req0 is mid-packet -> `grant`=0, `wr_uart`=0 next cycle; the following arbitration picks req0.
- With `UART_ARB_TIMEOUT_EN`, TIMEOUT=8: req0 sends 1 byte without last, then drops valid -> `timeout` pulses after 8 idle cycles and req1 is granted the following cycle. Without the macro, the grant is still held after 100 cycles.
- Single requester, `req_last` on every byte -> one byte every 2 cycles, `busy` toggling.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX FIFO write port among NREQ byte streams.
// Optional stalled-grant revocation is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ-1:0]   req_last_i,
  input  logic [8*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic              tx_full_i,
  output logic              wr_uart_o,
  output logic [7:0]        w_data_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int PW = $clog2(NREQ);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  logic [0:0]      state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   last_ptr_q, last_ptr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            busy_q;
  logic            timeout_q, timeout_d;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   cand_idx;
  int              cand;
  logic            owner_valid;
  logic            owner_last;
  logic [7:0]      owner_data;
  logic            locked;
  logic            accept;
  logic            revoke;

  assign locked = (state_q == ST_LOCKED);

  // First valid requester searching upward from the one after the previous owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand     = (int'(last_ptr_q) + 1 + i) % NREQ;
      cand_idx = PW'(cand);
      if (!pick_found && req_valid_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end else begin
        pick_found = pick_found;
      end
    end
  end

  // Select the current owner's lane.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == PW'(i)) begin
        owner_valid = req_valid_i[i];
        owner_last  = req_last_i[i];
        owner_data  = req_data_i[8*i +: 8];
      end else begin
        owner_data  = owner_data;
      end
    end
  end

  // Write port and handshake; reset blocks any transfer in the cycle it is asserted.
  always_comb begin
    req_ready_o = '0;
    wr_uart_o   = 1'b0;
    w_data_o    = 8'h00;
    if (locked && !rst) begin
      req_ready_o = grant_q & {NREQ{~tx_full_i}};
      wr_uart_o   = owner_valid & ~tx_full_i;
      w_data_o    = owner_data;
    end else begin
      w_data_o    = 8'h00;
    end
  end

  assign accept = wr_uart_o;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;

  assign revoke = locked && !owner_valid && (idle_cnt_q == CW'(TIMEOUT - 1));

  // Owner-idle run length; any cycle with the owner's valid high restarts it.
  always_comb begin
    if (locked && !owner_valid) begin
      idle_cnt_d = idle_cnt_q + CW'(1);
    end else begin
      idle_cnt_d = '0;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign revoke = 1'b0;
`endif

  // Grant state machine.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_ptr_d = last_ptr_q;
    grant_d    = grant_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_LOCKED;
          owner_d = pick_idx;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
        end else begin
          grant_d = '0;
        end
      end
      ST_LOCKED: begin
        if (accept && owner_last) begin
          state_d    = ST_IDLE;
          last_ptr_d = owner_q;
          grant_d    = '0;
        end else if (revoke) begin
          state_d    = ST_IDLE;
          last_ptr_d = owner_q;
          grant_d    = '0;
          timeout_d  = 1'b1;
        end else begin
          grant_d    = grant_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; last_ptr resets to the top index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_ptr_q <= PW'(NREQ - 1);
      grant_q    <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_ptr_q <= last_ptr_d;
      grant_q    <= grant_d;
      busy_q     <= |grant_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule
